// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares the single-ported main memory between the I-cache
// and D-cache refill paths. Grants one requester at a time in round-robin
// order, issues one line of consecutive word reads and streams the returned
// words back with a word index and an end-of-line pulse.
module mem_line_arbiter #(
    parameter int ADDR_SIZE      = 15,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [31:0]          mem_rdata,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic [IDX_W-1:0]     ridx,
    output logic                 done0,
    output logic                 done1
);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'(WORDS_PER_LINE - 1);

    state_t                 state, state_n;
    logic [ADDR_SIZE-1:0]   line_base, line_base_n;
    logic [IDX_W-1:0]       issue_cnt, issue_cnt_n;
    logic                   issuing, issuing_n;
    logic                   last_served, last_served_n;
    logic                   gnt0_n, gnt1_n;
    logic                   rvalid_n;
    logic [IDX_W-1:0]       ridx_n;
    logic                   done0_n, done1_n;
    logic [ADDR_SIZE-1:0]   mem_addr_n;
    logic                   winner;
    logic [ADDR_SIZE-1:0]   win_addr;
    logic [IDX_W-1:0]       idx_next;

    // Read data goes straight back to the requester; it is the only unregistered output.
    assign rdata = mem_rdata;

    // State and all registered outputs; reset abandons any burst without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            line_base   <= '0;
            issue_cnt   <= '0;
            issuing     <= 1'b0;
            last_served <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid      <= 1'b0;
            ridx        <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            mem_addr    <= '0;
        end else begin
            state       <= state_n;
            line_base   <= line_base_n;
            issue_cnt   <= issue_cnt_n;
            issuing     <= issuing_n;
            last_served <= last_served_n;
            gnt0        <= gnt0_n;
            gnt1        <= gnt1_n;
            rvalid      <= rvalid_n;
            ridx        <= ridx_n;
            done0       <= done0_n;
            done1       <= done1_n;
            mem_addr    <= mem_addr_n;
        end
    end

    // Arbitration, address issue and word-return sequencing; the word index only
    // ever touches the low bits, so a line at the top of memory cannot wrap.
    always_comb begin
        state_n       = state;
        line_base_n   = line_base;
        issue_cnt_n   = issue_cnt;
        issuing_n     = issuing;
        last_served_n = last_served;
        gnt0_n        = gnt0;
        gnt1_n        = gnt1;
        rvalid_n      = rvalid;
        ridx_n        = ridx;
        done0_n       = 1'b0;
        done1_n       = 1'b0;
        mem_addr_n    = mem_addr;
        winner        = 1'b0;
        win_addr      = addr0;
        idx_next      = issue_cnt + IDX_W'(1);

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    winner        = (req0 && req1) ? ~last_served : req1;
                    win_addr      = winner ? addr1 : addr0;
                    line_base_n   = win_addr & LINE_MASK;
                    mem_addr_n    = win_addr & LINE_MASK;
                    issue_cnt_n   = '0;
                    issuing_n     = 1'b1;
                    last_served_n = winner;
                    gnt0_n        = ~winner;
                    gnt1_n        = winner;
                    rvalid_n      = 1'b0;
                    ridx_n        = '0;
                    state_n       = BURST;
                end
            end
            BURST: begin
                if (issuing) begin
                    rvalid_n = 1'b1;
                    ridx_n   = issue_cnt;
                    if (issue_cnt == LAST_IDX) begin
                        issuing_n = 1'b0;
                        done0_n   = gnt0;
                        done1_n   = gnt1;
                    end else begin
                        issue_cnt_n = idx_next;
                        mem_addr_n  = line_base | ADDR_SIZE'(idx_next);
                    end
                end else begin
                    gnt0_n   = 1'b0;
                    gnt1_n   = 1'b0;
                    rvalid_n = 1'b0;
                    ridx_n   = '0;
                    state_n  = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Two-port arbiter and burst sequencer that shares the single-ported main memory model between the instruction-cache and data-cache refill paths. It accepts line-fill requests from two requesters, grants one at a time in round-robin order, and issues WORDS_PER_LINE consecutive word reads to memory. Returned words are streamed back to the granted requester with a word index and an end-of-line pulse. It sits between the cache controllers and main memory and is the only block that drives the memory address.

## Interface
- ADDR_SIZE, 15, word-address width; matches the memory address port.
- WORDS_PER_LINE, 4, words per cache line; power of two, 2..16.
- IDX_W, $clog2(WORDS_PER_LINE), width of the word index.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  line-fill request from requester 0 (I-cache) / 1 (D-cache); held until done.
- addr0 / addr1  in  ADDR_SIZE  any word address within the requested line.
- gnt0 / gnt1  out  1  high for the whole burst of the granted requester; one-hot or zero.
- mem_addr  out  ADDR_SIZE  registered word address to memory.
- mem_rdata  in  32  memory read data; valid one cycle after mem_addr is sampled.
- rdata  out  32  combinational copy of mem_rdata.
- rvalid  out  1  rdata holds a line word for the granted requester.
- ridx  out  IDX_W  index of the current word within the line (0 = line base).
- done0 / done1  out  1  single-cycle pulse with the last word of the line.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE: if req0 or req1 is high, pick the winner, latch base = addr & ~(WORDS_PER_LINE-1), set that gnt, set mem_addr = base and issue count = 0, then go to BURST.
- Round-robin: a last-served bit selects the winner on simultaneous requests. Reset value is 1, so requester 0 wins first. The bit updates to the winner at grant. A lone request always wins.
- BURST: each cycle mem_addr <= base + issue count + 1 until WORDS_PER_LINE addresses have been issued. After that, mem_addr holds the last address.
- A one-cycle-delayed issue flag drives rvalid, and a return counter drives ridx.
- When the last word returns, pulse done of the granted requester with that word, then go to DONE.
- DONE: clear gnt and rvalid, then go to IDLE. No requests are accepted in DONE.
- Address arithmetic is within the line only (low IDX_W bits), so there is no carry into the upper bits. This holds even for base = (1<<ADDR_SIZE) - WORDS_PER_LINE.
- Requester behaviour during a burst: deasserting req or changing addr is ignored, and the burst always completes. A second req sampled in DONE is not seen until IDLE.
- Reset (any state, including mid-burst): state IDLE; gnt0 = gnt1 = 0, rvalid = 0, done0 = done1 = 0, ridx = 0, mem_addr = 0, last-served = 1. No partial-line done is generated.

## Timing
- Cycle 0: IDLE with a request present. At the edge, gnt is set and mem_addr = base.
- Cycle 1: mem_addr = base, sampled by memory at the end of the cycle.
- Cycle 1+k (k = 1..W, where W = WORDS_PER_LINE): rvalid = 1, ridx = k-1, rdata = M[base+k-1].
- Cycle 1+W: done pulse.
- Cycle 2+W: state DONE with gnt = 0.
- Cycle 3+W: IDLE. The earliest next grant is visible in cycle 4+W.
- Throughput: one word per cycle. Per line the cost is W + 3 cycles, including arbitration and turnaround.
- Outputs are registered except rdata.

## Test plan
With main memory initialised M[i] = i and W = 4:
- Single request: req0 = 1, addr0 = 0x0013. Required: gnt0 in cycles 1..5; rvalid in cycles 2..5 with rdata 0x10, 0x11, 0x12, 0x13 and ridx 0..3; done0 in cycle 5; gnt1 and done1 stay 0.
- Simultaneous requests: req0 and req1 both high from reset, addr0 = 0x20, addr1 = 0x40. Required: line 0x20..0x23 to port 0, then line 0x40..0x43 to port 1, with gnt1 first high in cycle 8. Holding both requests yields strictly alternating grants.
- Back-to-back from one port: req1 held high with addr1 = 0x7FFE. Required: words 0x7FFC..0x7FFF, no wrap past line or memory end; repeated bursts are spaced exactly W + 3 cycles apart.
- Request drop mid-burst: after cycle 2, set req0 = 0 and change addr0. Required: all 4 words of the original line are returned, followed by done0.
- Reset mid-burst: assert reset in cycle 3 for one cycle. Required: the next cycle shows all outputs 0 and no done pulse. With req0 and req1 both pending, the next grant goes to port 0.
- Grant exclusivity: random reqs for 10k cycles. Required: gnt0 & gnt1 is never 1; rvalid only while a gnt is high; exactly one done per grant, with ridx == W-1 at that done.
